clk_period_meter: RTL

//  Measures a slow clock or pulse train (e.g. the 1 kHz output of slow_clock) against the 100 MHz system clk.

---
 rtl/clk_period_meter_pkg.sv | 15 +
 rtl/clk_period_meter_if.sv | 25 ++
 rtl/clk_period_meter_sync_edge_detect.sv | 37 +++
 rtl/clk_period_meter.sv | 115 +++++++++++
 4 files changed

// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the clock period meter: FSM state encoding
// and the default stall timeout derived from the system clock rate.
package clk_period_meter_pkg;

  localparam int CLK_HZ = 100_000_000;
  // 2 ms of silence at the system clock rate counts as a stalled input
  localparam int DEF_TIMEOUT = CLK_HZ / 500;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/clk_period_meter_if.sv
// Signal bundle between the meter and its user: measured input, enable,
// and the measurement results/status.
interface clk_period_meter_if #(
  parameter int CNT_W = 32
);
  logic             sig_in;
  logic             en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  // meas_valid is a one-cycle strobe with no ready: the consumer must take
  // period/high_time on the cycle meas_valid is high; they hold until the next strobe.
  modport master (
    output sig_in, en,
    input  period, high_time, meas_valid, timeout, busy
  );

  modport slave (
    input  sig_in, en,
    output period, high_time, meas_valid, timeout, busy
  );
endinterface

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a registered
// edge detector producing one-cycle rise/fall pulses.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow input in system-clock cycles,
// strobing each completed period and flagging a stalled input.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clk_period_meter_if.slave    bus,
  output state_e               state_o
);

  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

  logic             sig_level_unused;
  logic             rise;
  logic             fall;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] arm_cnt_q;
  logic             hi_open_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             meas_valid_q;
  logic             timeout_q;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (bus.sig_in),
    .level   (sig_level_unused),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_cnt_q     <= '0;
      arm_cnt_q    <= '0;
      hi_open_q    <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!bus.en) begin
        // Abort: results are kept, only the sticky flag is dropped
        state_q   <= IDLE;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= ARM;
            arm_cnt_q <= 1;
          end
          ARM: begin
            if (rise) begin
              state_q   <= MEASURE;
              cnt_q     <= 1;
              hi_cnt_q  <= 1;
              hi_open_q <= 1'b1;
            end else if (arm_cnt_q == TO_C) begin
              timeout_q <= 1'b1;
            end else begin
              arm_cnt_q <= arm_cnt_q + 1'b1;
            end
          end
          MEASURE: begin
            // Rise is checked first so it beats both a coincident fall and the timeout
            if (rise) begin
              period_q     <= cnt_q;
              high_time_q  <= hi_cnt_q;
              meas_valid_q <= 1'b1;
              timeout_q    <= 1'b0;
              cnt_q        <= 1;
              hi_cnt_q     <= 1;
              hi_open_q    <= 1'b1;
            end else if (cnt_q == TO_C) begin
              timeout_q <= 1'b1;
              state_q   <= ARM;
              arm_cnt_q <= 1;
            end else begin
              // cnt_q < TO_C here and hi_cnt_q <= cnt_q, so neither can pass TIMEOUT
              cnt_q <= cnt_q + 1'b1;
              if (fall) begin
                hi_open_q <= 1'b0;
              end else if (hi_open_q) begin
                hi_cnt_q <= hi_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = (state_q != IDLE);
  assign state_o        = state_q;

endmodule
